// File: rtl/alu_pkg.sv
// Shared types for the multicycle ALU: operation encoding and controller states.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_GT  = 4'd5,
    OP_EQ  = 4'd6,
    OP_XOR = 4'd7,
    OP_SLL = 4'd8,
    OP_SRL = 4'd9,
    OP_SRA = 4'd10,
    OP_MUL = 4'd11
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DONE
  } alu_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle for WIDTH cycles.
// prod carries the full product combinationally during the cycle that done pulses.
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CNT_W = $clog2(WIDTH);

  logic               busy;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_n;
  logic [WIDTH-1:0]   mplier;

  assign acc_n = mplier[0] ? acc + mcand : acc;
  assign done  = busy && (cnt == CNT_W'(WIDTH - 1));
  assign prod  = acc_n;

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // NOTE: datapath registers carry no reset; busy gates every use of them.
  always_ff @(posedge clk) begin
    if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
    end else if (busy) begin
      acc    <= acc_n;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multicycle ALU with valid/ready handshakes, registered result and flags,
// single-cycle logic/arith/shift ops and a WIDTH-cycle multiply.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OP_W  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WIDTH-1:0] result,
  output logic            zero,
  output logic            carry,
  output logic            ovf
);

  localparam int SH_W = $clog2(WIDTH);

  alu_state_t         state, state_n;
  logic               accept;
  logic               is_mul;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [SH_W-1:0]    shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic               alu_ovf;

  assign is_mul = (op == OP_MUL);
  assign accept = in_valid && in_ready;
  assign sum    = {1'b0, a} + {1'b0, b};
  assign diff   = {1'b0, a} - {1'b0, b};
  assign shamt  = b[SH_W-1:0];

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && is_mul),
    .a     (a),
    .b     (b),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (accept) state_n = is_mul ? ST_MUL : ST_DONE;
      ST_MUL:  if (mul_done) state_n = ST_DONE;
      ST_DONE: begin
        if (accept)         state_n = is_mul ? ST_MUL : ST_DONE;
        else if (out_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // The result slot frees up in the same cycle it is taken, hence in_ready follows out_ready in DONE.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: in_ready = rst_n;
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = rst_n && out_ready;
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];
        alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_GT:   alu_res = {{(WIDTH-1){1'b0}}, (a > b)};
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      default: ;
    endcase
  end

  // accept and mul_done are exclusive: no accept is possible while the multiplier runs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= '0;
      zero   <= 1'b0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept && !is_mul) begin
      result <= alu_res;
      zero   <= (alu_res == '0);
      carry  <= alu_carry;
      ovf    <= alu_ovf;
    end else if (mul_done) begin
      result <= mul_prod[WIDTH-1:0];
      zero   <= (mul_prod[WIDTH-1:0] == '0);
      carry  <= |mul_prod[2*WIDTH-1:WIDTH];
      ovf    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc at WIDTH=16: vector table, hand-built handshake
// sequences and randomized ops against an arithmetic reference model.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W = 16;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          zero;
  logic          carry;
  logic          ovf;

  int n_checks = 0;
  int n_pass   = 0;

  alu_mc #(.WIDTH(W), .OP_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .ovf       (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [3:0] op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic z;
    logic c;
    logic v;
    int lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Reference: {result, zero, carry, ovf} from plain integer arithmetic.
  function automatic logic [18:0] model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    longint ua, ub, full;
    int sa, sb, s, sh;
    logic [15:0] r;
    logic c, v;
    ua = longint'(x);
    ub = longint'(y);
    sa = int'($signed(x));
    sb = int'($signed(y));
    sh = int'(y) % W;
    r = '0; c = 1'b0; v = 1'b0;
    case (o)
      4'd1: begin
        full = ua + ub; r = 16'(full); c = (full > 65535);
        s = sa + sb; v = (s > 32767) || (s < -32768);
      end
      4'd2: begin
        full = ua - ub; r = 16'(full); c = (ua < ub);
        s = sa - sb; v = (s > 32767) || (s < -32768);
      end
      4'd3:  r = x & y;
      4'd4:  r = x | y;
      4'd5:  r = (ua > ub) ? 16'd1 : 16'd0;
      4'd6:  r = (ua == ub) ? 16'd1 : 16'd0;
      4'd7:  r = x ^ y;
      4'd8:  begin full = ua << sh; r = 16'(full); end
      4'd9:  begin full = ua >> sh; r = 16'(full); end
      4'd10: begin s = sa >>> sh; r = 16'(s); end
      4'd11: begin full = ua * ub; r = 16'(full); c = (full > 65535); end
      default: r = '0;
    endcase
    return {r, (r == 16'd0), c, v};
  endfunction

  // Starts at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    int g;
    g = 0;
    op = o; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
  endtask

  // Waits for out_valid (out_ready high), counts cycles from accept.
  task automatic recv(output logic [18:0] got, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
    got = {result, zero, carry, ovf};
    @(posedge clk); #1;
  endtask

  vec_t vecs[16];
  logic [18:0] got;
  logic [18:0] exp_q[$];
  logic [18:0] e;
  int lat;
  int busy_cycles;
  int stray;

  initial begin
    vecs[0]  = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1};
    vecs[1]  = '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 1};
    vecs[2]  = '{OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1};
    vecs[3]  = '{OP_SUB, 16'h0001, 16'h0002, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1};
    vecs[4]  = '{OP_MUL, 16'd300,  16'd300,  16'h5F90, 1'b0, 1'b1, 1'b0, 17};
    vecs[5]  = '{OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, 17};
    vecs[6]  = '{OP_SRA, 16'h8000, 16'h0014, 16'hF800, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{OP_SLL, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0, 1'b0, 1};
    vecs[8]  = '{OP_GT,  16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1};
    vecs[9]  = '{OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1};
    vecs[10] = '{OP_OR,  16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0, 1};
    vecs[11] = '{OP_EQ,  16'h0005, 16'h0005, 16'h0001, 1'b0, 1'b0, 1'b0, 1};
    vecs[12] = '{OP_XOR, 16'hAAAA, 16'hFFFF, 16'h5555, 1'b0, 1'b0, 1'b0, 1};
    vecs[13] = '{OP_SRL, 16'h8001, 16'h0010, 16'h8001, 1'b0, 1'b0, 1'b0, 1};
    vecs[14] = '{4'd13,  16'h0001, 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b0, 1};
    vecs[15] = '{OP_NOP, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs", {13'd0, result, zero, carry, ovf}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b);
      recv(got, lat);
      check($sformatf("vec%0d_result", i), 32'(got[18:3]), 32'(vecs[i].r));
      check($sformatf("vec%0d_flags_zcv", i), 32'(got[2:0]), 32'({vecs[i].z, vecs[i].c, vecs[i].v}));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Back-to-back SUBs: results on consecutive cycles, in_ready held high.
    op = OP_SUB; a = 16'h8000; b = 16'h0001; in_valid = 1'b1;
    @(negedge clk);
    check("b2b_ready_first", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    a = 16'h0001; b = 16'h0002;
    @(negedge clk);
    check("b2b_valid_first", 32'(out_valid), 32'd1);
    check("b2b_first", {13'd0, result, zero, carry, ovf}, {13'd0, 16'h7FFF, 3'b001});
    check("b2b_ready_second", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_valid_second", 32'(out_valid), 32'd1);
    check("b2b_second", {13'd0, result, zero, carry, ovf}, {13'd0, 16'hFFFF, 3'b010});
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_idle_after", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // MUL occupancy: in_ready low for exactly WIDTH cycles.
    send(OP_MUL, 16'd300, 16'd300);
    lat = 0; busy_cycles = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!in_ready) busy_cycles++;
    end while (!out_valid && lat < 200);
    check("mul_busy_cycles", 32'(busy_cycles), 32'd16);
    check("mul_latency", 32'(lat), 32'd17);
    check("mul_result", {13'd0, result, zero, carry, ovf}, {13'd0, 16'h5F90, 3'b010});
    @(posedge clk); #1;

    // Backpressure: held result, blocked concurrent request, transfer when out_ready rises.
    out_ready = 1'b0;
    send(OP_AND, 16'hF0F0, 16'h0FF0);
    op = OP_ADD; a = 16'h0001; b = 16'h0001; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("bp_hold%0d_result", k), 32'(result), 32'h00F0);
      check($sformatf("bp_hold%0d_in_ready", k), 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_result", 32'(result), 32'h00F0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_result", 32'(result), 32'h0002);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_drained", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of a multiply discards it.
    send(OP_MUL, 16'h1234, 16'h5678);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_outputs", {13'd0, result, zero, carry, ovf}, 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    stray = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    check("midrst_no_stray_output", 32'(stray), 32'd0);
    @(posedge clk); #1;
    send(OP_ADD, 16'd2, 16'd3);
    recv(got, lat);
    check("midrst_add_result", 32'(got[18:3]), 32'd5);
    check("midrst_add_latency", 32'(lat), 32'd1);

    // Random single ops, including MUL, against the model.
    for (int i = 0; i < 150; i++) begin
      logic [3:0] o;
      logic [15:0] x, y;
      o = 4'($urandom_range(0, 15));
      x = 16'($urandom);
      y = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 31)) : 16'($urandom);
      e = model(o, x, y);
      send(o, x, y);
      recv(got, lat);
      check($sformatf("rand%0d_op%0d", i, o), 32'(got), 32'(e));
      check($sformatf("rand%0d_latency", i), 32'(lat), (o == 4'd11) ? 32'd17 : 32'd1);
    end

    // Sustained burst of single-cycle ops: one result per cycle.
    for (int i = 0; i < 30; i++) begin
      logic [3:0] o;
      o = 4'($urandom_range(0, 15));
      if (o == 4'd11) o = 4'd7;
      op = o; a = 16'($urandom); b = 16'($urandom); in_valid = 1'b1;
      exp_q.push_back(model(o, a, b));
      @(negedge clk);
      check($sformatf("burst%0d_in_ready", i), 32'(in_ready), 32'd1);
      if (i > 0) begin
        e = exp_q.pop_front();
        check($sformatf("burst%0d_valid", i), 32'(out_valid), 32'd1);
        check($sformatf("burst%0d_result", i), 32'({result, zero, carry, ovf}), 32'(e));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    check("burst_last_valid", 32'(out_valid), 32'd1);
    check("burst_last_result", 32'({result, zero, carry, ovf}), 32'(e));
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
